decode_ibuf: RTL and testbench
==============================

Name: decode_ibuf

Overview:
- Parametrised instruction buffer between fetch and decode. Replaces the direct fetch-to-decode register.
- Accepts up to FETCH_WIDTH instructions per cycle and presents up to ISSUE_WIDTH in-order instructions to decode.
- Marks each issued instruction's delay-slot status.
- On a branch redirect flush, keeps a pending delay-slot instruction that has not yet issued, so decode never loses it.

Parameters:
- DEPTH, 8, entry count; power of 2, >= 2*max(FETCH_WIDTH, ISSUE_WIDTH).
- FETCH_WIDTH, 2, instructions offered per cycle by fetch.
- ISSUE_WIDTH, 2, instructions presented per cycle to decode; >= 1.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- flush  in  1  branch redirect; drops contents except a pending delay slot.
- flush_all  in  1  exception flush; drops everything; priority over flush.
- in_valid  in  FETCH_WIDTH  per-lane valid; must be contiguous from lane 0.
- in_instr  in  FETCH_WIDTH x 32  raw instructions.
- in_pc  in  FETCH_WIDTH x 32  instruction PCs.
- in_ready  out  1  buffer can take FETCH_WIDTH entries.
- out_valid  out  ISSUE_WIDTH  per-lane valid, contiguous from lane 0.
- out_instr  out  ISSUE_WIDTH x 32  raw instruction.
- out_pc  out  ISSUE_WIDTH x 32  PC.
- out_in_delay_slot  out  ISSUE_WIDTH  lane holds a delay-slot instruction.
- issue_ready  in  1  decode consumes all asserted out_valid lanes this cycle.

Behaviour:
- Storage: circular buffer of entries {instr, pc, is_ctl}, with head/tail pointers and a count. Pointers wrap modulo DEPTH.
- is_ctl is produced by predecode at enqueue. It is 1 for:
  - opcodes 0x01 (REGIMM) and 0x02–0x07;
  - SPECIAL funct 0x08 (JR) and 0x09 (JALR).
- Reset: count=0, head=tail=0, last_ctl=0, out_valid=0, in_ready=1.
- in_ready = (DEPTH − count) >= FETCH_WIDTH, using the registered count. Dequeues in the same cycle are not credited.
- Enqueue occurs when in_ready & |in_valid & ~flush & ~flush_all.
  - Lanes are written in order at tail.
  - tail and count advance by popcount(in_valid).
  - in_valid offered while in_ready=0 is ignored; fetch must hold it.
- Latency: an enqueued entry is visible on out_* the next cycle. There is no bypass.
- Issue group, formed combinationally from entries head..head+ISSUE_WIDTH−1 that exist:
  - Lane k is valid if entry k exists and no earlier lane j<k−1 is a control instruction.
  - Effect: the group ends at the lane following the first control instruction, i.e. its delay slot. At most one control instruction per group.
- out_in_delay_slot[0] = last_ctl. For k>0, out_in_delay_slot[k] = is_ctl of lane k−1.
- When issue_ready is high: head and count advance by popcount(out_valid), and last_ctl takes is_ctl of the highest valid lane.
- When issue_ready is low, or no lanes are valid, last_ctl holds.
- flush_all: count=0, head=tail, last_ctl=0. Enqueue and issue in the same cycle are discarded for buffer state.
- flush, without flush_all:
  - Issue in the same cycle is honoured first.
  - Compute last_ctl_next, i.e. last_ctl after that issue.
  - If last_ctl_next=1 and at least one entry remains, keep exactly the oldest remaining entry (count=1) and set last_ctl=1.
  - Otherwise set count=0 and last_ctl=0.
  - Same-cycle enqueue is dropped in both cases.
- Full: count never exceeds DEPTH, because in_ready guarantees room.
- Empty: out_valid=0, and issue_ready is ignored.

Optional Feature:
- Macro: DECODE_IBUF_PERF_EN.
- Defined: adds outputs perf_empty_cycles and perf_stall_cycles, each 32 bits, saturating, reset to 0.
  - perf_empty_cycles increments when count=0 and neither flush is active.
  - perf_stall_cycles increments when out_valid[0]=1 and issue_ready=0.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- decode_pkg gains:
  - typedef ibuf_entry_t {word_t instr; word_t pc; logic is_ctl;};
  - constants OP_SPECIAL=6'h00, OP_REGIMM=6'h01, FN_JR=6'h08, FN_JALR=6'h09.
- Sub-module ctl_predecode: combinational, 32-bit instr in, is_ctl out. One instance per fetch lane.

Test Plan:
1. Fill/drain, FW=IW=2, DEPTH=8:
   - Enqueue 0x24010001 at PC 0x1000 and 0x24020002 at PC 0x1004, with issue_ready=0, for 4 cycles.
   - Then in_ready=0 and count=8.
   - Then issue_ready=1: 2 lanes per cycle with PCs 0x1000, 0x1004, …; in_ready=1 once count<=6.
2. Branch grouping:
   - Buffer holds beq 0x10000003 at PC 0x2000, nop at 0x2004, addiu at 0x2008.
   - Group = 0x2000 and 0x2004 only, with out_in_delay_slot=2'b10.
   - The next cycle presents 0x2008 alone in lane 0, with delay-slot flag 0.
3. Pending delay slot with IW=1:
   - Issue beq at 0x3000, then assert flush in the next cycle.
   - Only nop at 0x3004 remains, presented with out_in_delay_slot=1.
   - Then last_ctl=0.
4. flush_all with the same pending state as scenario 3:
   - count=0, out_valid=0, last_ctl=0.
   - Same-cycle in_valid=2'b11 is not stored.
5. Partial fetch:
   - in_valid=2'b01, then 2'b11.
   - Issue order shows 3 PCs, strictly in program order.
6. With DECODE_IBUF_PERF_EN defined:
   - 3 empty cycles, then 2 cycles of valid data with issue_ready=0.
   - Result: perf_empty_cycles=3 and perf_stall_cycles=2.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared decode types and opcode constants
package decode_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        logic  is_ctl;
    } ibuf_entry_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

endpackage

// File: rtl/ctl_predecode.sv
// rtl/ctl_predecode.sv - flags instructions that own a delay slot
module ctl_predecode
    import decode_pkg::*;
(
    input  word_t instr,
    output logic  is_ctl
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_bits;

    assign op          = instr[31:26];
    assign fn          = instr[5:0];
    assign unused_bits = ^instr[25:6];

    // REGIMM through BGTZ (0x01..0x07) are all branches or jumps
    always_comb begin
        is_ctl = 1'b0;
        if (op == OP_SPECIAL) begin
            is_ctl = (fn == FN_JR) || (fn == FN_JALR);
        end else if (op >= OP_REGIMM && op <= 6'h07) begin
            is_ctl = 1'b1;
        end
    end

endmodule

// File: rtl/decode_ibuf.sv
// rtl/decode_ibuf.sv - fetch-to-decode instruction buffer; DECODE_IBUF_PERF_EN adds perf counters
module decode_ibuf
    import decode_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        flush,
    input  logic                        flush_all,
    input  logic [FETCH_WIDTH-1:0]      in_valid,
    input  logic [FETCH_WIDTH-1:0][31:0] in_instr,
    input  logic [FETCH_WIDTH-1:0][31:0] in_pc,
    output logic                        in_ready,
    output logic [ISSUE_WIDTH-1:0]      out_valid,
    output logic [ISSUE_WIDTH-1:0][31:0] out_instr,
    output logic [ISSUE_WIDTH-1:0][31:0] out_pc,
    output logic [ISSUE_WIDTH-1:0]      out_in_delay_slot,
`ifdef DECODE_IBUF_PERF_EN
    output logic [31:0]                 perf_empty_cycles,
    output logic [31:0]                 perf_stall_cycles,
`endif
    input  logic                        issue_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ibuf_entry_t            mem [DEPTH];
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [CW-1:0]          count;
    logic                   last_ctl;

    logic [FETCH_WIDTH-1:0] in_ctl;
    logic                   do_enq;
    logic [CW-1:0]          enq_cnt;
    logic [CW-1:0]          iss_cnt;
    logic [CW-1:0]          iss_n;
    logic                   hi_ctl;
    logic                   stop;
    logic                   prev_ctl;
    ibuf_entry_t            lane_e;
    logic [PW-1:0]          head_iss;
    logic [CW-1:0]          count_iss;
    logic                   last_ctl_next;

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_pre
        ctl_predecode u_pre (
            .instr  (in_instr[g]),
            .is_ctl (in_ctl[g])
        );
    end

    assign in_ready = (count <= CW'(DEPTH - FETCH_WIDTH));
    assign do_enq   = in_ready & (|in_valid) & ~flush & ~flush_all;

    always_comb begin
        enq_cnt = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (in_valid[i]) enq_cnt = enq_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (in_valid[i]) mem[tail + PW'(i)] <= '{in_instr[i], in_pc[i], in_ctl[i]};
            end
        end
    end

    // A lane is cut once a control instruction sits two or more lanes earlier,
    // so each group ends with at most one branch plus its delay slot.
    always_comb begin
        stop     = 1'b0;
        prev_ctl = last_ctl;
        iss_cnt  = '0;
        hi_ctl   = last_ctl;
        lane_e   = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            lane_e               = mem[head + PW'(k)];
            out_instr[k]         = lane_e.instr;
            out_pc[k]            = lane_e.pc;
            out_valid[k]         = (CW'(k) < count) && !stop;
            out_in_delay_slot[k] = prev_ctl;
            if (out_valid[k]) begin
                iss_cnt = iss_cnt + CW'(1);
                hi_ctl  = lane_e.is_ctl;
            end
            if (k >= 1) stop = stop | prev_ctl;
            prev_ctl = lane_e.is_ctl;
        end
    end

    assign iss_n         = issue_ready ? iss_cnt : '0;
    assign last_ctl_next = issue_ready ? hi_ctl : last_ctl;
    assign head_iss      = head + PW'(iss_n);
    assign count_iss     = count - iss_n;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            last_ctl <= 1'b0;
        end else if (flush_all) begin
            head     <= tail;
            count    <= '0;
            last_ctl <= 1'b0;
        end else if (flush) begin
            // an unissued delay slot survives the redirect as the sole entry
            head <= head_iss;
            if (last_ctl_next && count_iss != '0) begin
                tail     <= head_iss + PW'(1);
                count    <= CW'(1);
                last_ctl <= 1'b1;
            end else begin
                tail     <= head_iss;
                count    <= '0;
                last_ctl <= 1'b0;
            end
        end else begin
            head     <= head_iss;
            last_ctl <= last_ctl_next;
            if (do_enq) begin
                tail  <= tail + PW'(enq_cnt);
                count <= count_iss + enq_cnt;
            end else begin
                count <= count_iss;
            end
        end
    end

`ifdef DECODE_IBUF_PERF_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_empty_cycles <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (count == '0 && !flush && !flush_all && perf_empty_cycles != '1)
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
            if (out_valid[0] && !issue_ready && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_ibuf.sv
// tb/tb_decode_ibuf.sv - scoreboard bench for decode_ibuf (IW=2 and IW=1 instances)
module tb_decode_ibuf;

    localparam int DEPTH = 8;
    localparam int FW    = 2;

    localparam logic [31:0] I_BEQ   = 32'h10000003;
    localparam logic [31:0] I_NOP   = 32'h00000000;
    localparam logic [31:0] I_ADDIU = 32'h24030003;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                resetn;
    logic                flush;
    logic                flush_all;
    logic [FW-1:0]       in_valid;
    logic [FW-1:0][31:0] in_instr;
    logic [FW-1:0][31:0] in_pc;
    logic                issue_ready;

    logic                a_in_ready;
    logic [1:0]          a_out_valid;
    logic [1:0][31:0]    a_out_instr;
    logic [1:0][31:0]    a_out_pc;
    logic [1:0]          a_out_ds;

    logic                b_in_ready;
    logic [0:0]          b_out_valid;
    logic [0:0][31:0]    b_out_instr;
    logic [0:0][31:0]    b_out_pc;
    logic [0:0]          b_out_ds;

`ifdef DECODE_IBUF_PERF_EN
    logic [31:0] a_perf_empty, a_perf_stall, b_perf_empty, b_perf_stall;
`endif

    decode_ibuf #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(2)) dut_a (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .flush_all         (flush_all),
        .in_valid          (in_valid),
        .in_instr          (in_instr),
        .in_pc             (in_pc),
        .in_ready          (a_in_ready),
        .out_valid         (a_out_valid),
        .out_instr         (a_out_instr),
        .out_pc            (a_out_pc),
        .out_in_delay_slot (a_out_ds),
`ifdef DECODE_IBUF_PERF_EN
        .perf_empty_cycles (a_perf_empty),
        .perf_stall_cycles (a_perf_stall),
`endif
        .issue_ready       (issue_ready)
    );

    decode_ibuf #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(1)) dut_b (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .flush_all         (flush_all),
        .in_valid          (in_valid),
        .in_instr          (in_instr),
        .in_pc             (in_pc),
        .in_ready          (b_in_ready),
        .out_valid         (b_out_valid),
        .out_instr         (b_out_instr),
        .out_pc            (b_out_pc),
        .out_in_delay_slot (b_out_ds),
`ifdef DECODE_IBUF_PERF_EN
        .perf_empty_cycles (b_perf_empty),
        .perf_stall_cycles (b_perf_stall),
`endif
        .issue_ready       (issue_ready)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ds;
    } exp_t;

    exp_t sb[$];
    logic prev_ctl;
    int   total = 0;
    int   bad   = 0;

    function automatic logic model_ctl(input logic [31:0] i);
        logic [5:0] op;
        op = i[31:26];
        if (op == 6'h00) return (i[5:0] == 6'h08) || (i[5:0] == 6'h09);
        return (op >= 6'h01) && (op <= 6'h07);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.ds    = prev_ctl;
        sb.push_back(e);
        prev_ctl = model_ctl(instr);
    endtask

    task automatic do_reset;
        resetn      = 1'b0;
        flush       = 1'b0;
        flush_all   = 1'b0;
        in_valid    = '0;
        in_instr    = '0;
        in_pc       = '0;
        issue_ready = 1'b0;
        step;
        resetn = 1'b1;
        sb.delete();
        prev_ctl = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_a_in_ready: got %b want 1", a_in_ready); end
        total++; if (a_out_valid !== 2'b00) begin bad++; $display("FAIL reset_a_out_valid: got %b want 00", a_out_valid); end
        total++; if (a_out_ds[0] !== 1'b0) begin bad++; $display("FAIL reset_a_last_ctl: got %b want 0", a_out_ds[0]); end
        total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL reset_b_out_valid: got %b want 0", b_out_valid); end
    endtask

    task automatic test_fill_drain;
        exp_t e;
        logic [1:0] exp_v;
        do_reset;
        for (int c = 0; c < 4; c++) begin
            total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL fill_in_ready c%0d: got %b want 1", c, a_in_ready); end
            in_valid    = 2'b11;
            in_instr[0] = 32'h24010001;
            in_instr[1] = 32'h24020002;
            in_pc[0]    = 32'h1000 + 32'(8 * c);
            in_pc[1]    = 32'h1004 + 32'(8 * c);
            push(in_pc[0], in_instr[0]);
            push(in_pc[1], in_instr[1]);
            step;
        end
        in_valid = '0;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b want 0", a_in_ready); end
        step;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL full_hold_in_ready: got %b want 0", a_in_ready); end
        issue_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            exp_v = (sb.size() >= 2) ? 2'b11 : 2'b01;
            total++; if (a_out_valid !== exp_v) begin bad++; $display("FAIL drain_valid c%0d: got %b want %b", c, a_out_valid, exp_v); end
            total++; if (a_in_ready !== (sb.size() <= DEPTH - FW)) begin bad++; $display("FAIL drain_in_ready c%0d: got %b want %b", c, a_in_ready, sb.size() <= DEPTH - FW); end
            for (int k = 0; k < 2; k++) begin
                if (a_out_valid[k] && sb.size() > 0) begin
                    e = sb.pop_front();
                    total++;
                    if (a_out_pc[k] !== e.pc || a_out_instr[k] !== e.instr || a_out_ds[k] !== e.ds) begin
                        bad++;
                        $display("FAIL drain_lane%0d: got pc %h instr %h ds %b want pc %h instr %h ds %b",
                                 k, a_out_pc[k], a_out_instr[k], a_out_ds[k], e.pc, e.instr, e.ds);
                    end
                end
            end
            step;
        end
        issue_ready = 1'b0;
        total++; if (sb.size() != 0) begin bad++; $display("FAIL drain_timeout: got %0d left want 0", sb.size()); end
        total++; if (a_out_valid !== 2'b00) begin bad++; $display("FAIL drain_empty: got %b want 00", a_out_valid); end
    endtask

    task automatic test_branch_group;
        do_reset;
        in_valid = 2'b11;
        in_instr[0] = I_BEQ;   in_pc[0] = 32'h2000;
        in_instr[1] = I_NOP;   in_pc[1] = 32'h2004;
        step;
        in_valid = 2'b01;
        in_instr[0] = I_ADDIU; in_pc[0] = 32'h2008;
        step;
        in_valid = '0;
        total++; if (a_out_valid !== 2'b11) begin bad++; $display("FAIL br_valid: got %b want 11", a_out_valid); end
        total++; if (a_out_pc[0] !== 32'h2000 || a_out_pc[1] !== 32'h2004) begin bad++; $display("FAIL br_pcs: got %h %h want 2000 2004", a_out_pc[0], a_out_pc[1]); end
        total++; if (a_out_ds !== 2'b10) begin bad++; $display("FAIL br_ds: got %b want 10", a_out_ds); end
        issue_ready = 1'b1;
        step;
        issue_ready = 1'b0;
        total++; if (a_out_valid !== 2'b01) begin bad++; $display("FAIL br_next_valid: got %b want 01", a_out_valid); end
        total++; if (a_out_pc[0] !== 32'h2008 || a_out_ds[0] !== 1'b0) begin bad++; $display("FAIL br_next_lane0: got pc %h ds %b want 2008 0", a_out_pc[0], a_out_ds[0]); end
        flush = 1'b1;
        step;
        flush = 1'b0;
        total++; if (a_out_valid !== 2'b00) begin bad++; $display("FAIL plain_flush: got %b want 00", a_out_valid); end
    endtask

    task automatic load_pending_b;
        do_reset;
        in_valid = 2'b11;
        in_instr[0] = I_BEQ;   in_pc[0] = 32'h3000;
        in_instr[1] = I_NOP;   in_pc[1] = 32'h3004;
        step;
        in_valid = 2'b01;
        in_instr[0] = I_ADDIU; in_pc[0] = 32'h3008;
        step;
        in_valid = '0;
        total++; if (b_out_valid !== 1'b1 || b_out_pc[0] !== 32'h3000 || b_out_ds[0] !== 1'b0) begin
            bad++; $display("FAIL pend_head: got v %b pc %h ds %b want 1 3000 0", b_out_valid, b_out_pc[0], b_out_ds[0]);
        end
        issue_ready = 1'b1;
        step;
        issue_ready = 1'b0;
    endtask

    task automatic test_pending_slot;
        load_pending_b;
        flush = 1'b1;
        step;
        flush = 1'b0;
        total++; if (b_out_valid !== 1'b1 || b_out_pc[0] !== 32'h3004 || b_out_instr[0] !== I_NOP || b_out_ds[0] !== 1'b1) begin
            bad++; $display("FAIL pend_kept: got v %b pc %h ds %b want 1 3004 1", b_out_valid, b_out_pc[0], b_out_ds[0]);
        end
        step;
        total++; if (b_out_valid !== 1'b1 || b_out_pc[0] !== 32'h3004) begin bad++; $display("FAIL pend_hold: got v %b pc %h want 1 3004", b_out_valid, b_out_pc[0]); end
        issue_ready = 1'b1;
        step;
        issue_ready = 1'b0;
        total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL pend_dropped_rest: got %b want 0", b_out_valid); end
        total++; if (b_out_ds[0] !== 1'b0) begin bad++; $display("FAIL pend_last_ctl: got %b want 0", b_out_ds[0]); end
    endtask

    task automatic test_flush_all;
        load_pending_b;
        flush_all   = 1'b1;
        issue_ready = 1'b1;
        in_valid    = 2'b11;
        in_instr[0] = I_ADDIU; in_pc[0] = 32'h3100;
        in_instr[1] = I_ADDIU; in_pc[1] = 32'h3104;
        step;
        flush_all   = 1'b0;
        issue_ready = 1'b0;
        in_valid    = '0;
        total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL fa_valid: got %b want 0", b_out_valid); end
        total++; if (b_out_ds[0] !== 1'b0) begin bad++; $display("FAIL fa_last_ctl: got %b want 0", b_out_ds[0]); end
        total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL fa_in_ready: got %b want 1", b_in_ready); end
        step;
        total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL fa_no_store: got %b want 0", b_out_valid); end
    endtask

    task automatic test_partial;
        exp_t e;
        logic [31:0] last_pc;
        int seen;
        do_reset;
        in_valid = 2'b01;
        in_instr[0] = 32'h24050005; in_pc[0] = 32'h4000;
        push(in_pc[0], in_instr[0]);
        step;
        in_valid = 2'b11;
        in_instr[0] = 32'h24060006; in_pc[0] = 32'h4004;
        in_instr[1] = 32'h24070007; in_pc[1] = 32'h4008;
        push(in_pc[0], in_instr[0]);
        push(in_pc[1], in_instr[1]);
        step;
        in_valid    = '0;
        issue_ready = 1'b1;
        last_pc     = '0;
        seen        = 0;
        for (int c = 0; c < 8 && sb.size() > 0; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (a_out_valid[k] && sb.size() > 0) begin
                    e = sb.pop_front();
                    seen++;
                    total++;
                    if (a_out_pc[k] !== e.pc || a_out_instr[k] !== e.instr || a_out_pc[k] <= last_pc) begin
                        bad++; $display("FAIL partial_order: got pc %h instr %h want pc %h instr %h", a_out_pc[k], a_out_instr[k], e.pc, e.instr);
                    end
                    last_pc = a_out_pc[k];
                end
            end
            step;
        end
        issue_ready = 1'b0;
        total++; if (seen != 3 || sb.size() != 0) begin bad++; $display("FAIL partial_count: got %0d issued want 3", seen); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [31:0] pool [6];
        logic [31:0] pc_n;
        logic [1:0]  exp_v;
        pool = '{I_BEQ, 32'h03e00008, 32'h08000000, I_ADDIU, I_NOP, 32'h8c010000};
        do_reset;
        pc_n = 32'h5000;
        for (int c = 0; c < 300; c++) begin
            exp_v = (sb.size() >= 2) ? 2'b11 : (sb.size() == 1) ? 2'b01 : 2'b00;
            total++; if (a_out_valid !== exp_v) begin bad++; $display("FAIL b2b_valid c%0d: got %b want %b", c, a_out_valid, exp_v); end
            issue_ready = ($urandom_range(0, 2) != 0) || (c >= 250);
            if (issue_ready) begin
                for (int k = 0; k < 2; k++) begin
                    if (a_out_valid[k] && sb.size() > 0) begin
                        e = sb.pop_front();
                        if (a_out_pc[k] !== e.pc || a_out_instr[k] !== e.instr || a_out_ds[k] !== e.ds) begin
                            bad++;
                            $display("FAIL b2b_lane%0d: got pc %h instr %h ds %b want pc %h instr %h ds %b",
                                     k, a_out_pc[k], a_out_instr[k], a_out_ds[k], e.pc, e.instr, e.ds);
                        end
                    end
                end
            end
            in_valid = '0;
            if (a_in_ready && c < 240) begin
                case ($urandom_range(0, 2))
                    0: in_valid = 2'b00;
                    1: in_valid = 2'b01;
                    default: in_valid = 2'b11;
                endcase
                for (int k = 0; k < 2; k++) begin
                    in_instr[k] = pool[$urandom_range(0, 5)];
                    in_pc[k]    = pc_n;
                    if (in_valid[k]) begin
                        push(pc_n, in_instr[k]);
                        pc_n = pc_n + 32'd4;
                    end
                end
            end
            step;
        end
        in_valid    = '0;
        issue_ready = 1'b0;
        total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_leftover: got %0d want 0", sb.size()); end
    endtask

`ifdef DECODE_IBUF_PERF_EN
    task automatic test_perf;
        do_reset;
        step;
        step;
        in_valid = 2'b11;
        in_instr[0] = I_ADDIU; in_pc[0] = 32'h6000;
        in_instr[1] = I_ADDIU; in_pc[1] = 32'h6004;
        step;
        in_valid = '0;
        step;
        step;
        total++; if (a_perf_empty !== 32'd3) begin bad++; $display("FAIL perf_empty: got %0d want 3", a_perf_empty); end
        total++; if (a_perf_stall !== 32'd2) begin bad++; $display("FAIL perf_stall: got %0d want 2", a_perf_stall); end
    endtask
`endif

    initial begin
        test_reset;
        test_fill_drain;
        test_branch_group;
        test_pending_slot;
        test_flush_all;
        test_partial;
        test_back_to_back;
`ifdef DECODE_IBUF_PERF_EN
        test_perf;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
